// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter: round-robin sharing of the ULPI register port; define ULPI_REG_TIMEOUT_EN for a BUSY abort timer
module ulpi_reg_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_read_nwrite,
  input  logic [NREQ*6-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_error,
  output logic [5:0]        reg_addr,
  output logic [7:0]        reg_data_write,
  output logic              reg_enable,
  output logic              reg_read_nwrite,
  input  logic [7:0]        reg_data_read,
  input  logic              reg_done
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [IW-1:0] last_grant, nxt, idx;
  logic          found;
`ifdef ULPI_REG_TIMEOUT_EN
  logic [15:0]   cnt;
`endif
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("ulpi_reg_arbiter: parameter out of range");
  end
  // first pending requester after the last grant, wrapping
  always_comb begin
    found = 1'b0;
    nxt   = last_grant;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end
  // IDLE/BUSY transaction FSM with registered link and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= IW'(NREQ - 1);
      req_ack         <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_error       <= 1'b0;
      reg_addr        <= '0;
      reg_data_write  <= '0;
      reg_enable      <= 1'b0;
      reg_read_nwrite <= 1'b0;
`ifdef ULPI_REG_TIMEOUT_EN
      cnt             <= '0;
`endif
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      if (state == IDLE) begin
        if (found) begin
          state           <= BUSY;
          last_grant      <= nxt;
          req_ack         <= NREQ'(1) << nxt;
          reg_addr        <= req_addr[6*nxt +: 6];
          reg_data_write  <= req_wdata[8*nxt +: 8];
          reg_read_nwrite <= req_read_nwrite[nxt];
          reg_enable      <= 1'b1;
`ifdef ULPI_REG_TIMEOUT_EN
          cnt             <= '0;
`endif
        end
      end else if (reg_done) begin
        state      <= IDLE;
        reg_enable <= 1'b0;
        rsp_valid  <= NREQ'(1) << last_grant;
        rsp_rdata  <= reg_read_nwrite ? reg_data_read : 8'h00;
        rsp_error  <= 1'b0;
      end
`ifdef ULPI_REG_TIMEOUT_EN
      else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
        state      <= IDLE;
        reg_enable <= 1'b0;
        rsp_valid  <= NREQ'(1) << last_grant;
        rsp_rdata  <= 8'h00;
        rsp_error  <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
`endif
    end
  end
endmodule
